// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared matrix-datapath constants and write-back buffer types
//
// Purpose: matrix memory geometry defines, derived widths and the drain FSM
// state type used by the write-back buffer.
// Ports: none (package).

`ifndef ROW_NUM
`define ROW_NUM 4
`endif
`ifndef COL_NUM
`define COL_NUM 4
`endif
`ifndef MULITIPLICATION_NUM
`define MULITIPLICATION_NUM 4
`endif
`ifndef MATRIX_MEM_DATA_LENGTH
`define MATRIX_MEM_DATA_LENGTH 1
`endif
`ifndef MATRIX_MEM_READ_MSB_INDEX
`define MATRIX_MEM_READ_MSB_INDEX (`ROW_NUM*`COL_NUM*`MATRIX_MEM_DATA_LENGTH-1)
`endif
`ifndef MATRIX_MEM_DEPTH_BIT
`define MATRIX_MEM_DEPTH_BIT 4
`endif
`ifndef MATRIX_MEM_DEPTH
`define MATRIX_MEM_DEPTH (1 << `MATRIX_MEM_DEPTH_BIT)
`endif

package matrix_pkg;

  // One 4x4 GF(2) matrix per memory word.
  localparam int MATRIX_DATA_W = `MATRIX_MEM_READ_MSB_INDEX + 1;
  localparam int MATRIX_ADDR_W = `MATRIX_MEM_DEPTH_BIT;

  localparam int WB_DEPTH_DEF        = 4;
  localparam int WB_AFULL_MARGIN_DEF = 2;

  typedef enum logic [1:0] {
    DRN_IDLE   = 2'd0,
    DRN_ACTIVE = 2'd1,
    DRN_DONE   = 2'd2
  } drain_state_t;

endpackage

// File: rtl/matrix_wb_fifo.sv
// rtl/matrix_wb_fifo.sv - circular {addr, data} FIFO for the write-back buffer
//
// Purpose: storage, wrap-bit pointers, occupancy and full/empty for the
// write-back buffer. Also exposes every slot's address and validity so the
// parent can run the read-after-write hazard compare.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push, in_addr, in_data  enqueue request and payload (caller guarantees legality)
//   pop                   dequeue request (caller guarantees non-empty)
//   head_addr, head_data  oldest entry
//   full, empty, count    occupancy status
//   entry_addr, entry_vld per-slot address (flattened) and valid mask

module matrix_wb_fifo
  import matrix_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH_DEF,
  parameter int DATA_W = MATRIX_DATA_W,
  parameter int ADDR_W = MATRIX_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      pop,
  output logic [ADDR_W-1:0]         head_addr,
  output logic [DATA_W-1:0]         head_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DEPTH*ADDR_W-1:0]   entry_addr,
  output logic [DEPTH-1:0]          entry_vld
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  // Pointers run modulo 2*DEPTH; the top bit tells full apart from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Payload needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_idx] <= in_addr;
      data_mem[wr_idx] <= in_data;
    end
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign count     = wr_ptr - rd_ptr;
  assign head_addr = addr_mem[rd_idx];
  assign head_data = data_mem[rd_idx];

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [IDX_W-1:0] ofs;
    assign ofs          = IDX_W'(g) - rd_idx;
    assign entry_vld[g] = ({1'b0, ofs} < count);
    assign entry_addr[g*ADDR_W +: ADDR_W] = addr_mem[g];
  end

endmodule

// File: rtl/matrix_wb_buffer.sv
// rtl/matrix_wb_buffer.sv - write-back buffer between post-adder and matrix memory
//
// Purpose: absorbs post-adder results (which cannot stall) in a small FIFO and
// writes them to matrix memory under valid/ready. Provides almost_full
// back-pressure for the issue stage, a sticky overflow flag, a read-after-write
// hazard query and an end-of-program drain handshake.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   wb_vld_in, wb_rd_in, wb_data_in    incoming result and destination index
//   mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_ready   memory write port
//   almost_full                        stall request to issue stage
//   overflow                           sticky: a result was dropped
//   hz_query_addr, hz_hit              hazard query / pending-write match
//   drain_req, drain_done              flush request (level) / completion pulse
//   count                              current occupancy

module matrix_wb_buffer
  import matrix_pkg::*;
#(
  parameter int DEPTH        = WB_DEPTH_DEF,
  parameter int DATA_W       = MATRIX_DATA_W,
  parameter int ADDR_W       = MATRIX_ADDR_W,
  parameter int AFULL_MARGIN = WB_AFULL_MARGIN_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_vld_in,
  input  logic [ADDR_W-1:0]      wb_rd_in,
  input  logic [DATA_W-1:0]      wb_data_in,
  output logic                   mem_wr_en,
  output logic [ADDR_W-1:0]      mem_wr_addr,
  output logic [DATA_W-1:0]      mem_wr_data,
  input  logic                   mem_wr_ready,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic [ADDR_W-1:0]      hz_query_addr,
  output logic                   hz_hit,
  input  logic                   drain_req,
  output logic                   drain_done,
  output logic [$clog2(DEPTH):0] count
);

  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [DEPTH*ADDR_W-1:0] entry_addr;
  logic [DEPTH-1:0]        entry_vld;

  drain_state_t drn_state;
  drain_state_t drn_state_nxt;
  logic         drain_done_nxt;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop       = mem_wr_en & mem_wr_ready;
  assign push      = wb_vld_in & (~full | pop);
  assign mem_wr_en = ~empty;

  matrix_wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .in_addr    (wb_rd_in),
    .in_data    (wb_data_in),
    .pop        (pop),
    .head_addr  (mem_wr_addr),
    .head_data  (mem_wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .entry_addr (entry_addr),
    .entry_vld  (entry_vld)
  );

  // Margin covers results already inside the multiplier and post-adder.
  assign almost_full = (DEPTH - int'(count)) <= AFULL_MARGIN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wb_vld_in && !push) begin
      overflow <= 1'b1;
    end
  end

  // The head still counts while it pops: memory sees the write only at the edge.
  always_comb begin
    hz_hit = push && (wb_rd_in == hz_query_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (entry_addr[i*ADDR_W +: ADDR_W] == hz_query_addr)) begin
        hz_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drn_state  <= DRN_IDLE;
      drain_done <= 1'b0;
    end else begin
      drn_state  <= drn_state_nxt;
      drain_done <= drain_done_nxt;
    end
  end

  // Arrivals are still accepted while draining; completion waits for both
  // an empty FIFO and a quiet input.
  always_comb begin
    drn_state_nxt  = drn_state;
    drain_done_nxt = 1'b0;
    case (drn_state)
      DRN_IDLE: begin
        if (drain_req) drn_state_nxt = DRN_ACTIVE;
      end
      DRN_ACTIVE: begin
        if ((count == '0) && !wb_vld_in) begin
          drain_done_nxt = 1'b1;
          drn_state_nxt  = DRN_DONE;
        end
      end
      DRN_DONE: begin
        if (!drain_req) drn_state_nxt = DRN_IDLE;
      end
      default: drn_state_nxt = DRN_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_wb_buffer.sv
// tb/tb_matrix_wb_buffer.sv - scoreboard bench for matrix_wb_buffer

module tb_matrix_wb_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int AFULL  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wb_vld_in = 1'b0;
  logic [ADDR_W-1:0] wb_rd_in = '0;
  logic [DATA_W-1:0] wb_data_in = '0;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ready = 1'b0;
  logic              almost_full;
  logic              overflow;
  logic [ADDR_W-1:0] hz_query_addr = '0;
  logic              hz_hit;
  logic              drain_req = 1'b0;
  logic              drain_done;
  logic [2:0]        count;

  matrix_wb_buffer #(
    .DEPTH        (DEPTH),
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .AFULL_MARGIN (AFULL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_vld_in     (wb_vld_in),
    .wb_rd_in      (wb_rd_in),
    .wb_data_in    (wb_data_in),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ready  (mem_wr_ready),
    .almost_full   (almost_full),
    .overflow      (overflow),
    .hz_query_addr (hz_query_addr),
    .hz_hit        (hz_hit),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .count         (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer contents as a plain queue of {addr, data}.
  logic [ADDR_W+DATA_W-1:0] mq[$];
  logic [ADDR_W+DATA_W-1:0] sb_q[$];
  bit exp_ovf = 0;
  bit exp_done = 0;
  int drn_phase = 0;  // 0 waiting for request, 1 flushing, 2 waiting for release

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted memory write must match the oldest expected entry.
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    if (rst_n && mem_wr_en && mem_wr_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h, expected no write", mem_wr_addr);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", int'(mem_wr_addr), int'(e[ADDR_W+DATA_W-1:DATA_W]));
        check("wr_data", int'(mem_wr_data), int'(e[DATA_W-1:0]));
      end
    end
  end

  // One clock cycle: drive at posedge+1, check at negedge, advance model.
  task automatic cycle(input bit vld, input int rd, input int data, input bit rdy,
                       input int q, input bit dreq);
    int  sz;
    bit  pop;
    bit  acc;
    bit  hz;
    wb_vld_in     = vld;
    wb_rd_in      = ADDR_W'(rd);
    wb_data_in    = DATA_W'(data);
    mem_wr_ready  = rdy;
    hz_query_addr = ADDR_W'(q);
    drain_req     = dreq;
    @(negedge clk);
    sz  = mq.size();
    pop = (sz > 0) && rdy;
    acc = vld && ((sz < DEPTH) || pop);
    hz  = acc && (rd == q);
    foreach (mq[i]) if (int'(mq[i][ADDR_W+DATA_W-1:DATA_W]) == q) hz = 1;
    check("count", int'(count), sz);
    check("mem_wr_en", int'(mem_wr_en), int'(sz > 0));
    check("almost_full", int'(almost_full), int'((DEPTH - sz) <= AFULL));
    check("overflow", int'(overflow), int'(exp_ovf));
    check("hz_hit", int'(hz_hit), int'(hz));
    check("drain_done", int'(drain_done), int'(exp_done));
    #1;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back({ADDR_W'(rd), DATA_W'(data)});
      sb_q.push_back({ADDR_W'(rd), DATA_W'(data)});
    end
    if (vld && !acc) exp_ovf = 1;
    exp_done = 0;
    case (drn_phase)
      0: if (dreq) drn_phase = 1;
      1: if (sz == 0 && !vld) begin exp_done = 1; drn_phase = 2; end
      default: if (!dreq) drn_phase = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic reset_now();
    wb_vld_in = 0;
    drain_req = 0;
    rst_n = 0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_mem_wr_en", int'(mem_wr_en), 0);
    check("rst_almost_full", int'(almost_full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_drain_done", int'(drain_done), 0);
    check("rst_hz_hit", int'(hz_hit), 0);
    mq.delete();
    sb_q.delete();
    exp_ovf = 0;
    exp_done = 0;
    drn_phase = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic idle(input int n, input bit rdy, input int q, input bit dreq);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, rdy, q, dreq);
  endtask

  initial begin
    bit dr;
    #1;
    reset_now();

    // Single push, memory ready.
    cycle(1, 5, 16'h0001, 1, 0, 0);
    idle(3, 1, 0, 0);

    // Fill while blocked, then a push with a simultaneous pop on a full FIFO.
    for (int i = 1; i <= 4; i++) cycle(1, i, 16'h1000 + i, 0, 0, 0);
    cycle(1, 9, 16'h0099, 1, 9, 0);
    idle(6, 1, 0, 0);

    // Overflow: fifth push with no pop is dropped.
    for (int i = 1; i <= 5; i++) cycle(1, i, 16'h2000 + i, 0, 0, 0);
    idle(2, 0, 4, 0);
    idle(6, 1, 0, 0);
    reset_now();

    // Hazard query against queued rd 3 and 7, then an incoming rd=2.
    cycle(1, 3, 16'h0303, 0, 7, 0);
    cycle(1, 7, 16'h0707, 0, 7, 0);
    cycle(1, 1, 16'h0101, 0, 7, 0);
    cycle(1, 4, 16'h0404, 0, 7, 0);
    idle(5, 1, 7, 0);
    cycle(1, 2, 16'h0202, 0, 2, 0);
    idle(3, 1, 2, 0);

    // Ten back-to-back pushes, pointers wrap.
    for (int i = 0; i < 10; i++) cycle(1, i, 16'hA000 + i * 17, 1, 11, 0);
    idle(3, 1, 0, 0);

    // Drain with three entries pending, then hold the request.
    for (int i = 0; i < 3; i++) cycle(1, 12 + i, 16'hD000 + i, 0, 0, 0);
    idle(10, 1, 0, 1);
    idle(2, 1, 0, 0);

    // Reset while a drain is in progress.
    for (int i = 0; i < 2; i++) cycle(1, 6 + i, 16'hE000 + i, 0, 0, 0);
    idle(2, 0, 6, 1);
    reset_now();
    idle(3, 1, 0, 0);

    // Randomized traffic.
    dr = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) dr = ~dr;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 65535),
            $urandom_range(0, 2) != 0, $urandom_range(0, 7), dr);
    end

    idle(10, 1, 0, 0);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_wb_buffer.md
# matrix_wb_buffer

Write-back buffer between the post-adder stage and the matrix data memory write port. Captures each 4x4 GF(2) result matrix and its destination row index, holds them in a small FIFO, and issues them to the memory write port under a valid/ready handshake. Also provides back-pressure, an address-hazard query for the issue stage, and a drain handshake for end-of-program flush. The post-adder has no stall input, so this block is the pipeline's only point of elasticity.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 4
- DATA_W, `MATRIX_MEM_READ_MSB_INDEX+1, matrix payload width (ROW_NUM*COL_NUM*MATRIX_MEM_DATA_LENGTH)
- ADDR_W, `MATRIX_MEM_DEPTH_BIT, destination index width
- AFULL_MARGIN, 2, almost_full asserts when free entries ≤ this value

Ports:
- clk  in  1  clock. One clock for the whole block.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- wb_vld_in  in  1  result valid (from postadder_vld_out)
- wb_rd_in  in  ADDR_W  destination index (from rd_out)
- wb_data_in  in  DATA_W  result matrix (from matrix_out)
- mem_wr_en  out  1  write request to matrix memory
- mem_wr_addr  out  ADDR_W  write index
- mem_wr_data  out  DATA_W  write data
- mem_wr_ready  in  1  memory accepts write this cycle
- almost_full  out  1  stall request to the issue stage
- overflow  out  1  sticky flag: a result was dropped
- hz_query_addr  in  ADDR_W  index the issue stage intends to read
- hz_hit  out  1  hz_query_addr matches a pending write
- drain_req  in  1  flush request (level)
- drain_done  out  1  one-cycle pulse: flush complete
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: circular FIFO of {addr, data}, with wr_ptr and rd_ptr each $clog2(DEPTH)+1 bits wide (the extra bit is the wrap bit). full = indices equal and wrap bits differ. empty = pointers equal.
- Push = wb_vld_in & (~full | pop). When full with a same-cycle pop, the push is accepted.
- Pop = mem_wr_en & mem_wr_ready.
- wb_vld_in while full and no pop: the entry is dropped, overflow sets, and pointers are unchanged. overflow clears only on reset.
- mem_wr_en = ~empty; mem_wr_addr and mem_wr_data are the head entry. Head must stay stable while mem_wr_en=1 and mem_wr_ready=0.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- almost_full = (DEPTH − count) ≤ AFULL_MARGIN. This margin covers the multiplier and post-adder in flight.
- hz_hit is combinational: OR over valid entries of (addr == hz_query_addr), plus the incoming entry when push=1. Entries popping this cycle still count.
- Drain FSM:
  - IDLE: on drain_req, go to DRAIN.
  - DRAIN: when count==0 and wb_vld_in==0, pulse drain_done and go to DONE.
  - DONE: stay until drain_req==0, then go to IDLE.
  - Pushes stay accepted in every state.

## Timing
- Reset values: mem_wr_en=0, almost_full=0, overflow=0, hz_hit=0 (when no push), drain_done=0, count=0, pointers=0, FSM=IDLE. mem_wr_addr and mem_wr_data are don't-care while mem_wr_en=0.
- Latency: a push at edge N gives mem_wr_en=1 with that entry after edge N, so the earliest write is accepted at edge N+1.
- Throughput: one push and one pop per cycle sustained, with zero bubbles when mem_wr_ready stays high.
- Wrap-around: pointers roll over modulo 2·DEPTH, and ordering is preserved across the wrap.
- Mid-operation reset: contents are discarded immediately and asynchronously, and outputs take their reset values within the same cycle.
- drain_done: asserts the edge after the DRAIN exit condition is met, lasts exactly one cycle, and never fires in IDLE.

## Structure
- Shared package (matrix_pkg): ADDR_W/DATA_W-derived constants and the drain FSM state enum, alongside the existing `MATRIX_MEM_*, ROW_NUM, COL_NUM, MULITIPLICATION_NUM defines.
- One sub-module, matrix_wb_fifo: pointers, storage, count, full/empty.
- Top level holds the hazard compare, overflow flag and drain FSM.

## Test plan
- Single push {rd=5, data=0x0001}, mem_wr_ready=1: mem_wr_en=1 one cycle after the push with addr=5, data=0x0001; count returns to 0.
- mem_wr_ready=0, push 4 entries (rd 1..4): count=4 and almost_full=1 from count=2. A 5th push sets overflow=1 and count stays 4. Releasing ready then gives writes in order 1,2,3,4.
- Full FIFO, mem_wr_ready=1, simultaneous push rd=9: accepted, overflow stays 0, count stays 4, and rd=9 is written last.
- Queue 4 entries with rd 3 and 7, hz_query_addr=7: hz_hit=1. After the rd=7 entry pops, hz_hit=0. Incoming push rd=2 with query 2 gives hz_hit=1 in the same cycle.
- 10 back-to-back pushes with ready=1 throughout: 10 writes in order with no gaps, pointers wrap, overflow=0.
- drain_req=1 with 3 entries pending: drain_done pulses once, the cycle after the last pop. Holding drain_req gives no further pulses. rst_n low mid-drain gives count=0, FSM=IDLE, mem_wr_en=0 immediately.
